// File: rtl/qq_cmd_issuer_if.sv
// Bundle of user-side handshake and chain-head command signals for qq_cmd_issuer.
// slave is the issuer's view; master is the view of whoever drives it (user plus chain head).
interface qq_cmd_issuer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push_valid_i;
  logic [DATA_W-1:0] push_data_i;
  logic              push_ready_o;
  logic              pop_valid_i;
  logic              pop_ready_o;
  logic [DATA_W-1:0] pop_data_o;
  logic              pop_data_valid_o;
  logic              flush_i;
  logic              write_o;
  logic              read_o;
  logic              reset_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [DATA_W-1:0] rd_data_i;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;
  logic              busy_o;

  modport slave (
    input  push_valid_i, push_data_i, pop_valid_i, flush_i, rd_data_i,
    output push_ready_o, pop_ready_o, pop_data_o, pop_data_valid_o,
           write_o, read_o, reset_o, wr_data_o, count_o, full_o, empty_o, busy_o
  );

  modport master (
    output push_valid_i, push_data_i, pop_valid_i, flush_i, rd_data_i,
    input  push_ready_o, pop_ready_o, pop_data_o, pop_data_valid_o,
           write_o, read_o, reset_o, wr_data_o, count_o, full_o, empty_o, busy_o
  );
endinterface

// File: rtl/qq_cmd_issuer.sv
// QuickQ front-end: turns user push/pop handshakes into paced write/read/reset
// commands for the head node, tracks occupancy and returns popped data.
module qq_cmd_issuer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int CMD_GAP = 2,
  parameter int RD_LAT  = 2
) (
  input  logic           clk,
  input  logic           rst,
  qq_cmd_issuer_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GAP_W = (CMD_GAP > 2) ? $clog2(CMD_GAP - 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CMD_GAP > 1) ? CMD_GAP - 2 : 0);

  typedef enum logic [1:0] {SWEEP, IDLE, GAP} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  sweep_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [RD_LAT-1:0] rd_tag;
  logic              full, empty;
  logic              ready_ok, push_ready, pop_ready;
  logic              push_fire, pop_fire, sweep_issue;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  assign ready_ok   = (state == IDLE) && !bus.flush_i;
  assign push_ready = ready_ok && (!full || bus.pop_valid_i);
  assign pop_ready  = ready_ok && !empty;
  assign push_fire  = bus.push_valid_i && push_ready;
  assign pop_fire   = bus.pop_valid_i && pop_ready;

  assign bus.push_ready_o = push_ready;
  assign bus.pop_ready_o  = pop_ready;
  assign bus.count_o      = count;
  assign bus.full_o       = full;
  assign bus.empty_o      = empty;
  assign bus.busy_o       = !rst && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= SWEEP;
    else     state <= state_next;
  end

  // The sweep holds one extra cycle after its last decision so readies only
  // rise once the final reset command has left the issuer.
  always_comb begin
    state_next  = state;
    sweep_issue = 1'b0;
    case (state)
      SWEEP: begin
        sweep_issue = (sweep_cnt != CNT_W'(DEPTH)) && !bus.flush_i;
        if (sweep_cnt == CNT_W'(DEPTH)) state_next = IDLE;
      end
      IDLE: begin
        if ((push_fire || pop_fire) && (CMD_GAP > 1)) state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = IDLE;
      end
      default: state_next = SWEEP;
    endcase
    if (bus.flush_i) state_next = SWEEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count                <= '0;
      sweep_cnt            <= '0;
      gap_cnt              <= '0;
      rd_tag               <= '0;
      bus.write_o          <= 1'b0;
      bus.read_o           <= 1'b0;
      bus.reset_o          <= 1'b0;
      bus.wr_data_o        <= '0;
      bus.pop_data_o       <= '0;
      bus.pop_data_valid_o <= 1'b0;
    end else begin
      bus.write_o   <= push_fire;
      bus.read_o    <= pop_fire;
      bus.reset_o   <= sweep_issue;
      bus.wr_data_o <= push_fire ? bus.push_data_i : '0;

      if (bus.flush_i)  sweep_cnt <= '0;
      else if (sweep_issue) sweep_cnt <= sweep_cnt + CNT_W'(1);

      gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (bus.flush_i) count <= '0;
      else begin
        case ({push_fire, pop_fire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end

      // Tag shift register marks the cycle each read's data reaches the head;
      // a flush drops every tag so stale reads never report.
      rd_tag[0] <= bus.read_o && !bus.flush_i;
      for (int i = 1; i < RD_LAT; i++) rd_tag[i] <= rd_tag[i-1] && !bus.flush_i;

      bus.pop_data_valid_o <= rd_tag[RD_LAT-1] && !bus.flush_i;
      if (rd_tag[RD_LAT-1] && !bus.flush_i) bus.pop_data_o <= bus.rd_data_i;
    end
  end

  assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_qq_cmd_issuer.sv
// Directed bench for qq_cmd_issuer: sweep, push/pop, full, empty stall, flush
// and a CMD_GAP=1 instance, with a small queue model standing in for the chain.
module tb_qq_cmd_issuer;
  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   pass_count  = 0;

  always #5 clk = ~clk;

  qq_cmd_issuer_if #(.DATA_W(16), .DEPTH(16)) bus ();
  qq_cmd_issuer_if #(.DATA_W(16), .DEPTH(16)) bus1 ();

  qq_cmd_issuer #(.DATA_W(16), .DEPTH(16), .CMD_GAP(2), .RD_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  qq_cmd_issuer #(.DATA_W(16), .DEPTH(16), .CMD_GAP(1), .RD_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  // Chain head model: FIFO of written words, read data appears RD_LAT cycles after read_o.
  logic [15:0] chain_q[$];
  logic [15:0] head;
  logic [15:0] rd_pipe0 = '0;
  logic [15:0] rd_pipe1 = '0;

  always @(posedge clk) begin
    if (bus.reset_o) chain_q.delete();
    else begin
      if (bus.read_o && chain_q.size() > 0) begin
        head = chain_q.pop_front();
        rd_pipe0 <= head;
      end
      if (bus.write_o) chain_q.push_back(bus.wr_data_o);
    end
    rd_pipe1 <= rd_pipe0;
  end

  assign bus.rd_data_i  = rd_pipe1;
  assign bus1.rd_data_i = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    else
      pass_count++;
  endtask

  task automatic applyStimulus(input logic push_v, input logic [15:0] data,
                               input logic pop_v, input logic flush);
    bus.push_valid_i = push_v;
    bus.push_data_i  = data;
    bus.pop_valid_i  = pop_v;
    bus.flush_i      = flush;
  endtask

  // Hold a request until accepted (bounded), then return at the command cycle.
  task automatic do_op(input logic push_v, input logic [15:0] data, input logic pop_v);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    applyStimulus(push_v, data, pop_v, 1'b0);
    while (!ok && n < 20) begin
      #1;
      if ((!push_v || bus.push_ready_o) && (!pop_v || bus.pop_ready_o)) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) checkOutput("op_timeout", 32'd0, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int reset_hi;
    int valid_hi;
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    bus1.push_valid_i = 1'b0;
    bus1.push_data_i  = '0;
    bus1.pop_valid_i  = 1'b0;
    bus1.flush_i      = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset_outs",
      {bus.write_o, bus.read_o, bus.reset_o, bus.push_ready_o, bus.pop_ready_o,
       bus.pop_data_valid_o, bus.busy_o, bus.full_o, bus.empty_o, 11'(bus.count_o)},
      {9'b000000001, 11'd0});
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("sweep_c0", {bus.reset_o, bus.push_ready_o, bus.busy_o}, 3'b001);

    // Reset sweep: reset_o in cycles 1..16, push_ready from cycle 17
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("sweep_c%0d", k),
        {bus.reset_o, bus.push_ready_o, bus.empty_o},
        {(k <= 16) ? 1'b1 : 1'b0, (k >= 17) ? 1'b1 : 1'b0, 1'b1});
    end

    // Push 0x00A5 then pop it back
    applyStimulus(1'b1, 16'h00A5, 1'b0, 1'b0);
    #1;
    checkOutput("push_ready_idle", bus.push_ready_o, 1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("push_cmd", {bus.write_o, bus.wr_data_o}, {1'b1, 16'h00A5});
    checkOutput("push_count", bus.count_o, 1);
    checkOutput("push_ready_gap", bus.push_ready_o, 0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    checkOutput("pop_ready", {bus.pop_ready_o, bus.write_o, 16'(bus.wr_data_o)}, {1'b1, 1'b0, 16'h0});
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("pop_cmd", {bus.read_o, 8'(bus.count_o)}, {1'b1, 8'd0});
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("pop_ret_c%0d", k), {bus.pop_data_valid_o, bus.pop_data_o},
                  {(k == 6) ? 1'b1 : 1'b0, (k >= 6) ? 16'h00A5 : 16'h0000});
    end

    // Fill to full, then replace
    for (int i = 0; i < 16; i++) do_op(1'b1, 16'h0100 + 16'(i), 1'b0);
    #1;
    checkOutput("fill_count", {bus.full_o, 8'(bus.count_o)}, {1'b1, 8'd16});
    @(negedge clk);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    #1;
    checkOutput("full_ready", {bus.push_ready_o, bus.pop_ready_o}, 2'b01);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    #1;
    checkOutput("replace_ready", {bus.push_ready_o, bus.pop_ready_o}, 2'b11);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("replace_cmd", {bus.read_o, bus.write_o, bus.wr_data_o}, {2'b11, 16'hBEEF});
    checkOutput("replace_count", bus.count_o, 16);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("replace_ret_%0d", k), bus.pop_data_valid_o, (k == 3) ? 1 : 0);
    end
    checkOutput("replace_data", bus.pop_data_o, 16'h0100);

    // Flush one cycle after read_o
    do_op(1'b0, 16'h0, 1'b1);
    #1;
    checkOutput("flush_read", {bus.read_o, 8'(bus.count_o)}, {1'b1, 8'd15});
    @(negedge clk);
    applyStimulus(1'b1, 16'h7777, 1'b1, 1'b1);
    #1;
    checkOutput("flush_readies", {bus.push_ready_o, bus.pop_ready_o}, 2'b00);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("flush_state",
      {bus.write_o, bus.read_o, bus.reset_o, bus.empty_o, bus.busy_o, 8'(bus.count_o)},
      {5'b00011, 8'd0});
    reset_hi = 0;
    valid_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (bus.reset_o) reset_hi++;
      if (bus.pop_data_valid_o) valid_hi++;
    end
    checkOutput("flush_reset_cycles", reset_hi, 16);
    checkOutput("flush_no_valid", valid_hi, 0);
    checkOutput("flush_idle", {bus.busy_o, bus.push_ready_o}, 2'b01);

    // Empty stall: pop waits, simultaneous push goes alone
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    checkOutput("empty_pop_ready", {bus.pop_ready_o, bus.push_ready_o}, 2'b01);
    @(negedge clk);
    #1;
    checkOutput("empty_no_read", {bus.read_o, bus.pop_ready_o}, 2'b00);
    applyStimulus(1'b1, 16'h5A5A, 1'b1, 1'b0);
    #1;
    checkOutput("empty_push_only", {bus.push_ready_o, bus.pop_ready_o}, 2'b10);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    #1;
    checkOutput("empty_write", {bus.write_o, bus.read_o, bus.wr_data_o}, {2'b10, 16'h5A5A});
    checkOutput("empty_count", bus.count_o, 1);
    @(negedge clk);
    #1;
    checkOutput("stalled_pop_ready", bus.pop_ready_o, 1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    checkOutput("stalled_pop_cmd", {bus.read_o, 8'(bus.count_o)}, {1'b1, 8'd0});
    repeat (3) @(negedge clk);
    #1;
    checkOutput("stalled_pop_data", {bus.pop_data_valid_o, bus.pop_data_o}, {1'b1, 16'h5A5A});

    // CMD_GAP=1: four back-to-back pushes
    bus1.push_valid_i = 1'b1;
    bus1.push_data_i  = 16'h0011;
    #1;
    checkOutput("gap1_ready", bus1.push_ready_o, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) bus1.push_data_i = 16'h0011 * 16'(i + 1);
      else       bus1.push_valid_i = 1'b0;
      #1;
      checkOutput($sformatf("gap1_write_%0d", i), {bus1.write_o, bus1.wr_data_o},
                  {1'b1, 16'h0011 * 16'(i)});
    end
    @(negedge clk);
    #1;
    checkOutput("gap1_done", {bus1.write_o, 8'(bus1.count_o)}, {1'b0, 8'd4});

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/qq_cmd_issuer.md
Name: qq_cmd_issuer

Overview:
- Front-end initiator for the QuickQ node chain.
- Accepts push/pop requests from the user side with a valid/ready handshake. Issues write_o/read_o/reset_o commands into the head control node, paced to the chain's minimum command spacing.
- Tracks occupancy and returns popped data after a fixed read latency.
- On reset or flush, sweeps the chain with reset_o.

Parameters:
- DATA_W, 16, width of queue entries.
- DEPTH, 16, number of entries in the node chain; also the reset-sweep length in cycles.
- CMD_GAP, 2, minimum cycles between consecutive command issues (>=1).
- RD_LAT, 2, cycles from read_o high to valid rd_data_i at the chain head (>=1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- push_valid_i  in  1  user push request
- push_data_i  in  DATA_W  value to enqueue
- push_ready_o  out  1  push accepted when valid&ready
- pop_valid_i  in  1  user pop request
- pop_ready_o  out  1  pop accepted when valid&ready
- pop_data_o  out  DATA_W  dequeued value
- pop_data_valid_o  out  1  pop_data_o valid, one-cycle pulse
- flush_i  in  1  clear queue; starts a reset sweep
- write_o  out  1  write command to chain head
- read_o  out  1  read command to chain head
- reset_o  out  1  reset command to chain head
- wr_data_o  out  DATA_W  data accompanying write_o
- rd_data_i  in  DATA_W  data returned from chain head
- count_o  out  $clog2(DEPTH+1)  occupancy
- full_o  out  1  count_o==DEPTH
- empty_o  out  1  count_o==0
- busy_o  out  1  state!=IDLE

Behaviour:
- Reset (rst high):
  - All outputs 0, except empty_o=1.
  - count=0; state=SWEEP, sweep counter=0; in-flight read pipeline cleared.
- States:
  - SWEEP:
    - reset_o=1 every cycle for DEPTH cycles, starting the first cycle after rst deasserts.
    - Readies low; then go to IDLE.
  - IDLE:
    - push_ready_o = !full_o | pop_valid_i.
    - pop_ready_o = !empty_o.
    - Any accepted handshake goes to GAP if CMD_GAP>1; otherwise stay in IDLE.
  - GAP:
    - Readies low for CMD_GAP-1 cycles, then return to IDLE.
- Command outputs are registered. A handshake accepted in cycle t drives its command in cycle t+1 for exactly one cycle. wr_data_o = push_data_i captured at t; wr_data_o is 0 when write_o is low.
- Operations:
  - Push only: write_o, count+1.
  - Pop only (non-empty): read_o, count-1.
  - Push+pop same cycle, non-empty (including full): read_o and write_o in the same cycle (replace), count unchanged.
  - Push+pop while empty: only the push is accepted; the pop is stalled (pop_ready_o=0).
- Read return:
  - read_o in cycle t+1 → rd_data_i is sampled in cycle t+1+RD_LAT.
  - pop_data_o/pop_data_valid_o are registered: valid in cycle t+2+RD_LAT for one cycle.
  - pop_data_o holds its last value otherwise.
  - Up to ceil(RD_LAT/CMD_GAP)+1 reads may be in flight; use a shift-register tag, no FIFO.
- count_o changes in the cycle after the handshake (same edge as the command). full_o/empty_o are derived from the registered count.
- Flush:
  - flush_i in any state (including mid-SWEEP) goes to SWEEP on the next edge and restarts the sweep counter.
  - count=0.
  - In-flight read tags are cleared: no pop_data_valid_o for reads issued before the flush.
  - A handshake in the same cycle as flush_i is ignored (flush wins); readies are forced low when flush_i=1.
- rst mid-operation: identical to power-on reset; overrides flush.
- Overflow/underflow cannot occur; the ready logic prevents them. Assertion: count_o<=DEPTH at all times.

Test Plan:
- Reset sweep (DEPTH=16):
  - Stimulus: rst high 2 cycles, then low.
  - Required: reset_o high exactly cycles 1..16 after deassert; push_ready_o first high in cycle 17; empty_o=1 throughout.
- Push then pop (CMD_GAP=2, RD_LAT=2):
  - Stimulus: push 0x00A5 at cycle 0; model returns 0x00A5 when read.
  - Required: write_o and wr_data_o=0x00A5 in cycle 1; count_o=1; push_ready_o low in cycle 1.
  - Stimulus: pop accepted in cycle 2.
  - Required: read_o in cycle 3; pop_data_valid_o with 0x00A5 in cycle 6; count_o=0.
- Fill to full:
  - Stimulus: 16 pushes.
  - Required: full_o=1; push_ready_o=0 with pop_valid_i=0.
  - Stimulus: push+pop together.
  - Required: read_o and write_o in the same cycle; count_o stays 16.
- Empty stall:
  - Stimulus: pop_valid_i=1 with queue empty.
  - Required: pop_ready_o=0; no read_o.
  - Stimulus: simultaneous push.
  - Required: only write_o issued; pop accepted on the next IDLE cycle.
- Flush mid-read:
  - Stimulus: pop accepted, flush_i one cycle after read_o.
  - Required: no pop_data_valid_o pulse; reset_o high 16 cycles; count_o=0.
- CMD_GAP=1 back-to-back:
  - Stimulus: 4 consecutive pushes.
  - Required: write_o high 4 consecutive cycles; count_o=4.
